uart_rx_with_parity: RTL and testbench

//  Serial UART receiver; mirror of the parity-enabled transmitter. Deserialises
//  NUM_WORDS frames from rx into one W_OUT-bit word, checks parity and stop bits,
//  and presents the result on a valid/ready master stream. Sits at the pad-side

---
 rtl/uart_rx_with_parity.sv | 148 ++++++++++++++
 tb/tb_uart_rx_with_parity.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx_with_parity.sv
// UART receiver with parity and stop-bit checking; assembles NUM_WORDS frames
// into one W_OUT-bit word presented on a valid/ready stream with error flags.
module uart_rx_with_parity #(
  parameter int CLOCKS_PER_PULSE = 4,
  parameter int BITS_PER_WORD    = 8,
  parameter int PACKET_SIZE      = 13,
  parameter int W_OUT            = 16,
  parameter int PARITY_ODD       = 0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             rx,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [W_OUT-1:0] m_data,
  output logic             m_parity_err,
  output logic             m_frame_err,
  output logic             m_overrun
);
  localparam int NUM_WORDS = W_OUT / BITS_PER_WORD;
  localparam int STOP_BITS = PACKET_SIZE - BITS_PER_WORD - 2;
  localparam int BCMAX     = (BITS_PER_WORD > STOP_BITS) ? BITS_PER_WORD : STOP_BITS;
  localparam int CW        = $clog2(CLOCKS_PER_PULSE);
  localparam int BW        = $clog2(BCMAX + 1);
  localparam int WW        = $clog2(NUM_WORDS + 1);

  localparam logic [CW-1:0] HALF_LAST = CW'(CLOCKS_PER_PULSE / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLOCKS_PER_PULSE - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(BITS_PER_WORD - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic [WW-1:0] WORD_LAST = WW'(NUM_WORDS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                   state;
  logic                     rx_p0, rx_p1, rx_p2;
  logic [CW-1:0]            clk_cnt;
  logic [BW-1:0]            bit_cnt;
  logic [WW-1:0]            word_cnt;
  logic [BITS_PER_WORD-1:0] shreg;
  logic [W_OUT-1:0]         pkt_data, pkt_data_nxt;
  logic                     pkt_pe, pkt_fe, fe_nxt;
  logic                     tick, stop_zero, frame_end, pkt_done;

  function automatic logic parity_bit(input logic [BITS_PER_WORD-1:0] d);
    return (PARITY_ODD != 0) ? ~^d : ^d;
  endfunction

  // rx_p0/rx_p1 synchronise the line; rx_p2 holds the previous synced value for edge detect
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
      rx_p2 <= 1'b1;
    end else begin
      rx_p0 <= rx;
      rx_p1 <= rx_p0;
      rx_p2 <= rx_p1;
    end
  end

  always_comb begin
    tick         = (state == START) ? (clk_cnt == HALF_LAST) : (clk_cnt == BIT_LAST);
    stop_zero    = (state == STOP) && tick && !rx_p1;
    frame_end    = (state == STOP) && tick && (!rx_p1 || bit_cnt == STOP_LAST);
    pkt_done     = frame_end && (word_cnt == WORD_LAST);
    fe_nxt       = pkt_fe | stop_zero;
    pkt_data_nxt = pkt_data;
    for (int i = 0; i < NUM_WORDS; i++)
      if (word_cnt == WW'(i)) pkt_data_nxt[i*BITS_PER_WORD +: BITS_PER_WORD] = shreg;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      clk_cnt      <= '0;
      bit_cnt      <= '0;
      word_cnt     <= '0;
      shreg        <= '0;
      pkt_data     <= '0;
      pkt_pe       <= 1'b0;
      pkt_fe       <= 1'b0;
      m_valid      <= 1'b0;
      m_data       <= '0;
      m_parity_err <= 1'b0;
      m_frame_err  <= 1'b0;
      m_overrun    <= 1'b0;
    end else begin
      clk_cnt <= tick ? '0 : clk_cnt + 1'b1;
      case (state)
        IDLE: begin
          clk_cnt <= '0;
          bit_cnt <= '0;
          if (rx_p2 && !rx_p1) state <= START;
        end
        START: if (tick) state <= rx_p1 ? IDLE : DATA;
        DATA: if (tick) begin
          shreg <= {rx_p1, shreg[BITS_PER_WORD-1:1]};
          if (bit_cnt == DATA_LAST) begin
            bit_cnt <= '0;
            state   <= PARITY;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        PARITY: if (tick) begin
          if (rx_p1 != parity_bit(shreg)) pkt_pe <= 1'b1;
          state <= STOP;
        end
        STOP: if (tick) begin
          if (frame_end) begin
            state   <= IDLE;
            bit_cnt <= '0;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      // A stop-bit error still counts as a received word so packet alignment is kept
      if (frame_end) begin
        pkt_data <= pkt_data_nxt;
        if (pkt_done) begin
          word_cnt <= '0;
          pkt_pe   <= 1'b0;
          pkt_fe   <= 1'b0;
        end else begin
          word_cnt <= word_cnt + 1'b1;
          pkt_fe   <= fe_nxt;
        end
      end

      if (pkt_done && (!m_valid || m_ready)) begin
        m_valid      <= 1'b1;
        m_data       <= pkt_data_nxt;
        m_parity_err <= pkt_pe;
        m_frame_err  <= fe_nxt;
        if (m_valid) m_overrun <= 1'b0;
      end else if (pkt_done) begin
        m_overrun <= 1'b1;
      end else if (m_valid && m_ready) begin
        m_valid   <= 1'b0;
        m_overrun <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_with_parity.sv
// Bench for uart_rx_with_parity: a behavioural transmitter drives frames and a
// scoreboard checks every accepted output word and its flags.
module tb_uart_rx_with_parity;
  localparam int CPP = 4;

  logic        clk = 1'b0;
  logic        rstn, rx, m_valid, m_ready, m_parity_err, m_frame_err, m_overrun;
  logic [15:0] m_data;

  uart_rx_with_parity #(
    .CLOCKS_PER_PULSE(CPP), .BITS_PER_WORD(8), .PACKET_SIZE(13), .W_OUT(16), .PARITY_ODD(0)
  ) dut (
    .clk(clk), .rstn(rstn), .rx(rx), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_parity_err(m_parity_err), .m_frame_err(m_frame_err),
    .m_overrun(m_overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic        pe, fe;
  } exp_t;

  typedef struct {
    logic [7:0]  w0, w1;
    logic        pf0, pf1;
    logic [2:0]  st0, st1;
    logic [15:0] d;
    logic        pe, fe;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[7];
  int   nchk = 0;
  int   nerr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bit_wait();
    repeat (CPP) @(negedge clk);
  endtask

  // Frame: start, 8 data LSB first, parity (even, optionally flipped), 3 stop bits;
  // a 0 stop bit ends the frame after which the line returns to idle.
  task automatic send_frame(input logic [7:0] d, input logic pflip, input logic [2:0] stops);
    rx = 1'b0; bit_wait();
    for (int i = 0; i < 8; i++) begin rx = d[i]; bit_wait(); end
    rx = (^d) ^ pflip; bit_wait();
    for (int i = 0; i < 3; i++) begin
      rx = stops[i]; bit_wait();
      if (!stops[i]) break;
    end
    rx = 1'b1; bit_wait();
  endtask

  task automatic send_vec(input vec_t v);
    sb.push_back('{d: v.d, pe: v.pe, fe: v.fe});
    send_frame(v.w0, v.pf0, v.st0);
    send_frame(v.w1, v.pf1, v.st1);
  endtask

  // Monitor: sampled mid-cycle, one comparison per accepted handshake
  always @(negedge clk) begin
    #2;
    if (rstn && m_valid && m_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_output", {16'h0, m_data}, 32'hDEAD_0000);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("m_data", {16'h0, m_data}, {16'h0, e.d});
        check("m_parity_err", {31'h0, m_parity_err}, {31'h0, e.pe});
        check("m_frame_err", {31'h0, m_frame_err}, {31'h0, e.fe});
      end
    end
  end

  initial begin
    logic [15:0] r;
    tbl[0] = '{8'hA5, 8'h3C, 1'b0, 1'b0, 3'b111, 3'b111, 16'h3CA5, 1'b0, 1'b0};
    tbl[1] = '{8'hA5, 8'h3C, 1'b0, 1'b1, 3'b111, 3'b111, 16'h3CA5, 1'b1, 1'b0};
    tbl[2] = '{8'h5A, 8'h11, 1'b0, 1'b0, 3'b101, 3'b111, 16'h115A, 1'b0, 1'b1};
    tbl[3] = '{8'h22, 8'h33, 1'b0, 1'b0, 3'b111, 3'b111, 16'h3322, 1'b0, 1'b0};
    tbl[4] = '{8'h00, 8'hFF, 1'b0, 1'b0, 3'b111, 3'b111, 16'hFF00, 1'b0, 1'b0};
    tbl[5] = '{8'hC3, 8'h96, 1'b1, 1'b0, 3'b111, 3'b110, 16'h96C3, 1'b1, 1'b1};
    tbl[6] = '{8'h01, 8'h80, 1'b0, 1'b0, 3'b111, 3'b111, 16'h8001, 1'b0, 1'b0};

    rstn = 1'b0; rx = 1'b1; m_ready = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    check("rst_m_valid", {31'h0, m_valid}, 32'h0);
    check("rst_m_data", {16'h0, m_data}, 32'h0);
    check("rst_flags", {29'h0, m_parity_err, m_frame_err, m_overrun}, 32'h0);
    @(negedge clk); rstn = 1'b1;
    bit_wait();

    for (int i = 0; i < 6; i++) begin
      send_vec(tbl[i]);
      bit_wait();
    end

    // One-cycle glitch must be rejected at the start-bit mid-sample
    rx = 1'b0; @(negedge clk); rx = 1'b1;
    bit_wait(); bit_wait();
    send_vec(tbl[6]);
    bit_wait();

    // Line stuck low: exactly one framing-error frame (data 0), no restart until high
    rx = 1'b0;
    repeat (20) bit_wait();
    rx = 1'b1; bit_wait(); bit_wait();
    sb.push_back('{d: 16'h7700, pe: 1'b0, fe: 1'b1});
    send_frame(8'h77, 1'b0, 3'b111);
    bit_wait();

    // Overrun: second packet dropped while the first waits
    m_ready = 1'b0;
    sb.push_back('{d: 16'h1234, pe: 1'b0, fe: 1'b0});
    send_frame(8'h34, 1'b0, 3'b111);
    send_frame(8'h12, 1'b0, 3'b111);
    send_frame(8'hEF, 1'b0, 3'b111);
    send_frame(8'hBE, 1'b0, 3'b111);
    bit_wait();
    #2;
    check("ovr_m_valid", {31'h0, m_valid}, 32'h1);
    check("ovr_m_data", {16'h0, m_data}, 32'h1234);
    check("ovr_m_overrun", {31'h0, m_overrun}, 32'h1);
    @(negedge clk); m_ready = 1'b1;
    @(negedge clk); #2;
    check("post_hs_m_valid", {31'h0, m_valid}, 32'h0);
    check("post_hs_m_overrun", {31'h0, m_overrun}, 32'h0);

    // Reset in the middle of word 1's data bits
    send_frame(8'hAA, 1'b0, 3'b111);
    rx = 1'b0; bit_wait();
    for (int i = 0; i < 3; i++) begin rx = i[0]; bit_wait(); end
    rstn = 1'b0; #1;
    check("midrst_m_valid", {31'h0, m_valid}, 32'h0);
    check("midrst_m_data", {16'h0, m_data}, 32'h0);
    check("midrst_flags", {29'h0, m_parity_err, m_frame_err, m_overrun}, 32'h0);
    rx = 1'b1;
    @(negedge clk); @(negedge clk); rstn = 1'b1;
    bit_wait(); bit_wait();
    sb.push_back('{d: 16'hCAFE, pe: 1'b0, fe: 1'b0});
    send_frame(8'hFE, 1'b0, 3'b111);
    send_frame(8'hCA, 1'b0, 3'b111);
    bit_wait();

    // Loopback of random words
    for (int i = 0; i < 10; i++) begin
      r = 16'($urandom);
      sb.push_back('{d: r, pe: 1'b0, fe: 1'b0});
      send_frame(r[7:0], 1'b0, 3'b111);
      send_frame(r[15:8], 1'b0, 3'b111);
    end

    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    check("scoreboard_drained", sb.size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
